// File: rtl/vx_csr_req_arb.sv
// vx_csr_req_arb: round-robin arbiter/sequencer sharing one CSR unit among
// NUM_REQS dispatch slices. A grant is held from the sop packet through the
// eop packet. Optional feature macro: CSR_ARB_DRAIN_EN. When it is defined,
// the arbiter waits in DRAIN for the scheduler's alm_empty before the first
// packet is forwarded. When it is undefined, IDLE goes straight to XFER.
module vx_csr_req_arb #(
  parameter int NUM_REQS = 4,
  parameter int DATAW    = 128,
  parameter int WID_W    = 4,
  parameter int IDX_W    = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_REQS-1:0]             req_valid,
  input  logic [NUM_REQS-1:0][DATAW-1:0]  req_data,
  input  logic [NUM_REQS-1:0][WID_W-1:0]  req_wid,
  input  logic [NUM_REQS-1:0]             req_sop,
  input  logic [NUM_REQS-1:0]             req_eop,
  output logic [NUM_REQS-1:0]             req_ready,
  output logic [WID_W-1:0]                alm_empty_wid,
  input  logic                            alm_empty,
  output logic                            rsp_valid,
  output logic [DATAW-1:0]                rsp_data,
  output logic [WID_W-1:0]                rsp_wid,
  output logic                            rsp_sop,
  output logic                            rsp_eop,
  output logic [IDX_W-1:0]                rsp_idx,
  input  logic                            rsp_ready,
  output logic                            busy,
  output logic [15:0]                     drain_cycles
);

`ifdef CSR_ARB_DRAIN_EN
  localparam bit DRAIN_EN = 1'b1;
`else
  localparam bit DRAIN_EN = 1'b0;
`endif

  typedef enum logic [1:0] {ST_IDLE, ST_DRAIN, ST_XFER} state_t;

  state_t             state;
  logic [IDX_W-1:0]   grant;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   next_ptr;
  logic [WID_W-1:0]   last_wid;
  logic [NUM_REQS-1:0] elig;
  logic               pick_vld;
  logic [IDX_W-1:0]   pick_idx;
  logic [IDX_W-1:0]   cand;
  logic               xfer_rdy;
  logic               req_fire;

  // Output register can take a new packet when empty or being drained.
  assign xfer_rdy = (state == ST_XFER) & (~rsp_valid | rsp_ready);

  // Per-lane eligibility (only sop packets start an instruction) and ready.
  for (genvar i = 0; i < NUM_REQS; i++) begin : g_lane
    assign elig[i]      = req_valid[i] & req_sop[i];
    assign req_ready[i] = xfer_rdy & (grant == IDX_W'(i));
  end

  assign req_fire = |(req_valid & req_ready);
  assign next_ptr = (grant == IDX_W'(NUM_REQS - 1)) ? '0 : grant + IDX_W'(1);
  assign busy     = (state != ST_IDLE) | rsp_valid;

  // Live wid of the owning slice while draining, else the last granted wid.
  assign alm_empty_wid = !DRAIN_EN ? '0 :
                         (state == ST_DRAIN) ? req_wid[grant] : last_wid;

  // Cyclic priority search starting at rr_ptr.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int k = 0; k < NUM_REQS; k++) begin
      cand = IDX_W'((int'(rr_ptr) + k) % NUM_REQS);
      if (!pick_vld && elig[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  // Grant/lock FSM: grant on sop, optional drain wait, release on eop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      grant        <= '0;
      rr_ptr       <= '0;
      last_wid     <= '0;
      drain_cycles <= '0;
    end else begin
      case (state)
        ST_IDLE: if (pick_vld) begin
          grant    <= pick_idx;
          last_wid <= req_wid[pick_idx];
          state    <= DRAIN_EN ? ST_DRAIN : ST_XFER;
        end
        ST_DRAIN: begin
          if (drain_cycles != 16'hFFFF) drain_cycles <= drain_cycles + 16'd1;
          if (alm_empty) state <= ST_XFER;
        end
        ST_XFER: if (req_fire && req_eop[grant]) begin
          rr_ptr <= next_ptr;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Output register: a load wins over a pop, so back-to-back stays valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_wid   <= '0;
      rsp_sop   <= 1'b0;
      rsp_eop   <= 1'b0;
      rsp_idx   <= '0;
    end else if (req_fire) begin
      rsp_valid <= 1'b1;
      rsp_data  <= req_data[grant];
      rsp_wid   <= req_wid[grant];
      rsp_sop   <= req_sop[grant];
      rsp_eop   <= req_eop[grant];
      rsp_idx   <= grant;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vx_csr_req_arb.sv
// Scoreboard bench for vx_csr_req_arb. Adapts expected latencies and drain
// observables to whether CSR_ARB_DRAIN_EN is defined for the build.
`timescale 1ns/1ps
module tb_vx_csr_req_arb;
  localparam int N  = 4;
  localparam int DW = 128;
  localparam int WW = 4;
  localparam int IW = 2;
`ifdef CSR_ARB_DRAIN_EN
  localparam bit DRAIN = 1'b1;
`else
  localparam bit DRAIN = 1'b0;
`endif
  localparam int LAT = DRAIN ? 3 : 2;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [WW-1:0] wid;
    logic          sop;
    logic          eop;
    logic [IW-1:0] idx;
  } pkt_t;

  logic                   clk, reset;
  logic [N-1:0]           req_valid, req_sop, req_eop, req_ready;
  logic [N-1:0][DW-1:0]   req_data;
  logic [N-1:0][WW-1:0]   req_wid;
  logic [WW-1:0]          alm_empty_wid, rsp_wid;
  logic                   alm_empty, rsp_valid, rsp_sop, rsp_eop, rsp_ready, busy;
  logic [DW-1:0]          rsp_data;
  logic [IW-1:0]          rsp_idx;
  logic [15:0]            drain_cycles;

  pkt_t slice_q [N][$];
  pkt_t exp_q   [N][$];
  pkt_t sb      [$];
  logic [N-1:0] fire;
  int total = 0;
  int bad   = 0;

  vx_csr_req_arb #(.NUM_REQS(N), .DATAW(DW), .WID_W(WW), .IDX_W(IW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_data(req_data), .req_wid(req_wid),
    .req_sop(req_sop), .req_eop(req_eop), .req_ready(req_ready),
    .alm_empty_wid(alm_empty_wid), .alm_empty(alm_empty),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_wid(rsp_wid),
    .rsp_sop(rsp_sop), .rsp_eop(rsp_eop), .rsp_idx(rsp_idx),
    .rsp_ready(rsp_ready), .busy(busy), .drain_cycles(drain_cycles)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Per-slice driver and response monitor. Inputs change at negedge; the
  // handshakes that will happen at the next posedge are sampled at +4.
  always @(negedge clk) begin
    for (int i = 0; i < N; i++)
      if (fire[i] && slice_q[i].size() > 0) void'(slice_q[i].pop_front());
    for (int i = 0; i < N; i++) begin
      if (slice_q[i].size() > 0) begin
        req_valid[i] = 1'b1;
        req_data[i]  = slice_q[i][0].data;
        req_wid[i]   = slice_q[i][0].wid;
        req_sop[i]   = slice_q[i][0].sop;
        req_eop[i]   = slice_q[i][0].eop;
      end else begin
        req_valid[i] = 1'b0;
        req_sop[i]   = 1'b0;
        req_eop[i]   = 1'b0;
      end
    end
    #4;
    fire = req_valid & req_ready;
    if (rsp_valid && rsp_ready) begin
      if (sb.size() == 0) chk("sb_underflow", 32'(sb.size()), 1);
      else begin
        pkt_t e;
        e = sb.pop_front();
        chk("rsp_data", rsp_data, e.data);
        chk("rsp_meta", {rsp_wid, rsp_sop, rsp_eop, rsp_idx}, {e.wid, e.sop, e.eop, e.idx});
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #2;
    end
  endtask

  task automatic add_instr(input int s, input int n, input logic [WW-1:0] wid);
    for (int k = 0; k < n; k++) begin
      pkt_t p;
      p.data = {$urandom, $urandom, $urandom, $urandom};
      p.wid  = wid;
      p.sop  = (k == 0);
      p.eop  = (k == n - 1);
      p.idx  = IW'(s);
      slice_q[s].push_back(p);
      exp_q[s].push_back(p);
    end
  endtask

  // Expected grant order is decided by the test: move one whole instruction.
  task automatic expect_instr(input int s);
    pkt_t p;
    do begin
      p = exp_q[s].pop_front();
      sb.push_back(p);
    end while (!p.eop && exp_q[s].size() > 0);
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int c = 0;
    while (sb.size() != 0 && c < budget) begin
      tick();
      c++;
    end
    chk(tag, 32'(sb.size()), 0);
  endtask

  task automatic flush_bench();
    for (int i = 0; i < N; i++) begin
      slice_q[i].delete();
      exp_q[i].delete();
    end
    sb.delete();
    fire = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    flush_bench();
    tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    int viol, c;
    reset = 1'b1; rsp_ready = 1'b1; alm_empty = 1'b1; fire = '0;
    req_valid = '0; req_sop = '0; req_eop = '0; req_data = '0; req_wid = '0;
    tick(2);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_drain", drain_cycles, 0);
    chk("rst_alm_wid", alm_empty_wid, 0);
    chk("rst_rsp_idx", rsp_idx, 0);
    reset = 1'b0;
    tick();

    // Round robin: two single-packet instructions per slice, order 0..3,0..3.
    for (int r = 0; r < 2; r++)
      for (int s = 0; s < N; s++) add_instr(s, 1, WW'(s + 4 * r));
    for (int r = 0; r < 2; r++)
      for (int s = 0; s < N; s++) expect_instr(s);
    wait_idle(100, "rr_done");

    // Single packet on slice 2, wid 5 (rr_ptr is 0 here).
    add_instr(2, 1, 4'd5);
    expect_instr(2);
    tick();                                   // cycle t: grant in IDLE
    chk("sp_t_ready", req_ready, 0);
    tick();                                   // t+1
    chk("sp_alm_wid", alm_empty_wid, DRAIN ? 5 : 0);
    tick(LAT - 2);                            // XFER cycle
    chk("sp_xfer_ready", req_ready, 4'b0100);
    chk("sp_pre_valid", rsp_valid, 0);
    tick();                                   // t+LAT
    chk("sp_valid", rsp_valid, 1);
    chk("sp_idx", rsp_idx, 2);
    tick();
    chk("sp_busy", busy, 0);
    chk("sp_alm_hold", alm_empty_wid, DRAIN ? 5 : 0);

    // Lock: slice 0 three packets, slice 1 waits (rr_ptr now 3 -> slice 0 first).
    add_instr(0, 3, 4'd1);
    add_instr(1, 1, 4'd2);
    expect_instr(0);
    expect_instr(1);
    viol = 0; c = 0;
    while (slice_q[0].size() > 0 && c < 50) begin
      tick();
      c++;
      if (req_ready[1]) viol++;
    end
    chk("lock_r1_ready", viol, 0);
    wait_idle(50, "lock_done");

    // Drain wait: alm_empty low for 10 cycles after the grant.
    do_reset();
    alm_empty = 1'b0;
    add_instr(3, 1, 4'd9);
    expect_instr(3);
    tick();                                   // cycle t
    viol = 0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (req_ready != 0) viol++;
      if (k == 5) chk("dr_alm_wid", alm_empty_wid, DRAIN ? 9 : 0);
      if (k == 10) alm_empty = 1'b1;
    end
    chk("dr_no_ready", viol, DRAIN ? 0 : 1);
    tick();                                   // t+11
    chk("dr_fwd_ready", req_ready, DRAIN ? 4'b1000 : 4'b0000);
    chk("dr_cycles", drain_cycles, DRAIN ? 10 : 0);
    wait_idle(20, "dr_done");

    // Backpressure: 4-packet instruction on slice 1, rsp_ready low 4 cycles.
    add_instr(1, 4, 4'd3);
    expect_instr(1);
    c = 0;
    while (!rsp_valid && c < 20) begin
      tick();
      c++;
    end
    chk("bp_first", rsp_valid, 1);
    tick();
    rsp_ready = 1'b0;
    #1;
    chk("bp_stall_ready", req_ready, 0);
    for (int k = 0; k < 4; k++) begin
      chk("bp_hold_valid", rsp_valid, 1);
      chk("bp_hold_data", rsp_data, sb[0].data);
      tick();
    end
    rsp_ready = 1'b1;
    wait_idle(30, "bp_done");

    // Async reset mid-XFER, then the next grant must be slice 0.
    add_instr(2, 3, 4'd6);
    expect_instr(2);
    c = 0;
    while (!rsp_valid && c < 20) begin
      tick();
      c++;
    end
    chk("ar_in_xfer", rsp_valid, 1);
    reset = 1'b1;
    #1;
    chk("ar_rsp_valid", rsp_valid, 0);
    chk("ar_req_ready", req_ready, 0);
    chk("ar_busy", busy, 0);
    flush_bench();
    tick();
    reset = 1'b0;
    add_instr(2, 3, 4'd6);
    add_instr(0, 1, 4'd7);
    expect_instr(0);
    expect_instr(2);
    wait_idle(50, "ar_done");
    tick(2);
    chk("end_busy", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/vx_csr_req_arb.md
# vx_csr_req_arb

Round-robin arbiter and sequencer that shares one CSR unit among `NUM_REQS` issue slices. It grants one multi-packet CSR instruction at a time and holds the grant from the `sop` packet through the `eop` packet. Before the first packet is forwarded, it waits until the scheduler reports that the owning warp has no pending instructions. It sits between the per-slice SFU dispatch outputs and the CSR unit's execute input, and it owns the scheduler's `alm_empty` query.

## Interface

Parameters:
- NUM_REQS, 4, number of requesting dispatch slices (≥1)
- DATAW, 128, opaque payload width per packet (uuid/tmask/PC/rd/operands)
- WID_W, 4, warp-id width
- IDX_W, `UP(`CLOG2(NUM_REQS)), grant index width

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
  - clk in 1 clock
  - reset in 1 asynchronous, active-high
- Request side, one lane per slice (NUM_REQS lanes):
  - req_valid in NUM_REQS packet valid per slice
  - req_data in NUM_REQS*DATAW packet payload
  - req_wid in NUM_REQS*WID_W warp id of packet
  - req_sop in NUM_REQS first packet of instruction
  - req_eop in NUM_REQS last packet of instruction
  - req_ready out NUM_REQS packet accepted when valid&ready
- Scheduler query:
  - alm_empty_wid out WID_W warp queried to the scheduler
  - alm_empty in 1 queried warp has no instructions in flight
- Response side, toward the CSR unit:
  - rsp_valid out 1 registered packet valid
  - rsp_data out DATAW registered payload
  - rsp_wid out WID_W registered warp id
  - rsp_sop out 1 registered sop
  - rsp_eop out 1 registered eop
  - rsp_idx out IDX_W source slice of rsp packet
  - rsp_ready in 1 downstream accept
- Status:
  - busy out 1 state ≠ IDLE or rsp_valid
  - drain_cycles out 16 saturating count of cycles spent in DRAIN

## Operation

- States:
  - IDLE: select the first slice at or after `rr_ptr` (cyclic) with `req_valid & req_sop`. Register it as `grant` and go to DRAIN. A valid packet without `sop` is never granted from IDLE. No `req_ready` is asserted in IDLE.
  - DRAIN:
    - Drive `alm_empty_wid = req_wid[grant]`.
    - When `alm_empty=1`, go to XFER.
    - Each cycle spent in DRAIN increments `drain_cycles`, which saturates at 0xFFFF.
  - XFER:
    - Drive `req_ready[grant] = ~rsp_valid | rsp_ready`. All other `req_ready` bits are 0.
    - On a handshake, load the output register with the data, wid, sop, eop and `grant` of the accepted packet.
    - A handshake on a packet with `eop=1`: set `rr_ptr = grant+1`, wrapping to 0 at NUM_REQS, and go to IDLE.
- Output register:
  - Cleared when `rsp_valid & rsp_ready` and no new load occurs in the same cycle.
  - A simultaneous pop and load keeps `rsp_valid=1` with the new contents.
- Single-packet instruction (`sop=eop=1`): passes IDLE→DRAIN→XFER→IDLE.
- Outside DRAIN, `alm_empty_wid` holds the last granted wid.
- NUM_REQS=1: `rr_ptr` is constant 0.
- Reset values: state IDLE; `rr_ptr`, `grant`, `drain_cycles` = 0; all outputs 0 (`rsp_valid`, `req_ready`, `busy` low).
- Reset mid-instruction discards any held packet and the lock. The requester must re-present the instruction from `sop`.

## Timing

- Fastest path, for a grant in IDLE at cycle t:
  - t+1: DRAIN, with `alm_empty=1` sampled.
  - t+2: XFER, handshake.
  - t+3: `rsp_valid=1`.
- First-packet latency is therefore 3 cycles plus any DRAIN wait.
- Throughput: 1 packet/cycle within an instruction while `rsp_ready=1`.
- Turnaround: 2 idle cycles between instructions (eop→IDLE→DRAIN).
- `req_ready` is combinational from state and `rsp_valid`/`rsp_ready` only, never from `req_valid`.

## Configuration

- `CSR_ARB_DRAIN_EN` defined: DRAIN state present, behaviour as above.
- `CSR_ARB_DRAIN_EN` undefined:
  - IDLE goes directly to XFER.
  - `alm_empty` is ignored and `alm_empty_wid` is tied to 0.
  - `drain_cycles` stays 0.
  - Fastest first-packet latency becomes 2 cycles.

## Test plan

- Single packet: slice 2, `sop=eop=1`, wid=5, `alm_empty=1`, `rsp_ready=1` → `alm_empty_wid=5` at t+1, `rsp_valid` with `rsp_idx=2` at t+3, then `busy=0`.
- Lock: slice 0 sends 3 packets (sop, -, eop) while slice 1 is valid throughout → `rsp_idx` reads 0,0,0, then 1; `req_ready[1]=0` until slice 0's eop is accepted.
- Round robin: all 4 slices continuously request single-packet instructions → grant order 0,1,2,3,0.
- Drain wait: `alm_empty=0` for 10 cycles after the grant → no `req_ready`; `drain_cycles=10`; forwarding begins the cycle after `alm_empty` rises.
- Backpressure: `rsp_ready=0` for 4 cycles mid-instruction → `rsp_data` stable, no loss or duplication, in-order delivery after release.
- Async reset asserted mid-XFER, between clock edges → `rsp_valid`, `req_ready`, `busy` are 0 immediately; after reset the next grant is slice 0.
